// File: rtl/dragon_body_pkg.sv
// +----------------------------------------------------------------------------+
// | dragon_body_pkg                                                            |
// | Shared constants and types for the dragon body tracker.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package dragon_body_pkg;

   localparam int LOC_W                = 8;
   localparam int DIR_W                = 2;
   localparam int DEFAULT_MAX_SEGMENTS = 15;

   typedef enum logic [DIR_W-1:0] {
      UP    = 2'd0,
      RIGHT = 2'd1,
      DOWN  = 2'd2,
      LEFT  = 2'd3
   } dir_t;

endpackage

`default_nettype wire

// File: rtl/dragon_body_segment_match.sv
// +----------------------------------------------------------------------------+
// | segment_match                                                              |
// | Combinational any-hit compare of one location against a masked array.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module segment_match
   import dragon_body_pkg::*;
#(
   parameter int N = DEFAULT_MAX_SEGMENTS
) (
   input  logic [LOC_W-1:0]   i_loc,
   input  logic [LOC_W*N-1:0] i_locs,
   input  logic [N-1:0]       i_mask,
   output logic               o_hit
);

   logic [N-1:0] w_eq;

   generate
      for (genvar i = 0; i < N; i++) begin : g_cmp
         assign w_eq[i] = i_mask[i] && (i_locs[LOC_W*i +: LOC_W] == i_loc);
      end
   endgenerate

   assign o_hit = |w_eq;

endmodule

`default_nettype wire

// File: rtl/dragon_body.sv
// +----------------------------------------------------------------------------+
// | dragon_body                                                                |
// | Shift-register body tracker with length control and collision detect.    |
// | Optional macro: DRAGON_SELF_COLLIDE_EN enables self-collision detection.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dragon_body
   import dragon_body_pkg::*;
#(
   parameter int               MAX_SEGMENTS = DEFAULT_MAX_SEGMENTS,
   parameter int               INIT_LEN     = 2,
   parameter logic [LOC_W-1:0] START_LOC    = 8'h77
) (
   input  logic                        frame_clk,
   input  logic                        rst_n,
   input  logic                        move_valid,
   input  logic [LOC_W-1:0]            head_location,
   input  logic [1:0]                  head_direction,
   input  logic                        grow,
   input  logic                        shrink,
   input  logic [LOC_W-1:0]            player_location,
   output logic [3:0]                  body_length,
   output logic [LOC_W*MAX_SEGMENTS-1:0] segment_locations,
   output logic [2*MAX_SEGMENTS-1:0]   segment_directions,
   output logic [MAX_SEGMENTS-1:0]     segment_valid,
   output logic [LOC_W-1:0]            head_q,
   output logic                        player_hit,
   output logic                        self_collision,
   output logic                        dragon_dead
);

   localparam logic [3:0] c_max_len  = 4'(MAX_SEGMENTS);
   localparam logic [3:0] c_init_len = 4'(INIT_LEN);

   logic [LOC_W-1:0]              r_head;
   dir_t                          r_head_dir;
   logic [LOC_W*MAX_SEGMENTS-1:0] r_seg_loc;
   logic [2*MAX_SEGMENTS-1:0]     r_seg_dir;
   logic [3:0]                    r_len;
   logic                          r_dead;
   logic                          r_player_hit;

   logic                          w_move;
   logic [LOC_W*MAX_SEGMENTS-1:0] w_shift_loc;
   logic [2*MAX_SEGMENTS-1:0]     w_shift_dir;
   logic [MAX_SEGMENTS-1:0]       w_valid;
   logic [3:0]                    w_len_mv;
   logic [3:0]                    w_len_nx;
   logic                          w_dead_nx;
   logic                          w_player_hit;

   assign w_move = move_valid && !r_dead;

   // Slot 0 takes the old head; every slot shifts regardless of validity.
   generate
      for (genvar i = 0; i < MAX_SEGMENTS; i++) begin : g_slot
         if (i == 0) begin : g_first
            assign w_shift_loc[0 +: LOC_W] = r_head;
            assign w_shift_dir[0 +: 2]     = r_head_dir;
         end else begin : g_rest
            assign w_shift_loc[LOC_W*i +: LOC_W] = r_seg_loc[LOC_W*(i-1) +: LOC_W];
            assign w_shift_dir[2*i +: 2]         = r_seg_dir[2*(i-1) +: 2];
         end
         assign w_valid[i] = (4'(i) < r_len);
      end
   endgenerate

`ifdef DRAGON_SELF_COLLIDE_EN
   logic                    r_self_coll;
   logic                    w_self_hit;
   logic [MAX_SEGMENTS-1:0] w_valid_nx;

   generate
      for (genvar i = 0; i < MAX_SEGMENTS; i++) begin : g_mask_nx
         assign w_valid_nx[i] = (4'(i) < w_len_mv);
      end
   endgenerate

   segment_match #(.N(MAX_SEGMENTS)) u_self_match (
      .i_loc  (head_location),
      .i_locs (w_shift_loc),
      .i_mask (w_valid_nx),
      .o_hit  (w_self_hit)
   );

   always_ff @(posedge frame_clk or negedge rst_n) begin
      if (!rst_n) r_self_coll <= 1'b0;
      else        r_self_coll <= w_move && w_self_hit;
   end

   assign self_collision = r_self_coll;
`else
   assign self_collision = 1'b0;
`endif

   always_comb begin
      w_len_mv  = r_len;
      w_dead_nx = r_dead;
      if (w_move) begin
         if (grow && !shrink) begin
            if (r_len != c_max_len) w_len_mv = r_len + 4'd1;
         end else if (shrink && !grow) begin
            if (r_len == 4'd1) w_dead_nx = 1'b1;
            else               w_len_mv  = r_len - 4'd1;
         end
      end
      w_len_nx = w_len_mv;
`ifdef DRAGON_SELF_COLLIDE_EN
      // A collision pulse costs one segment, stacked on any move change.
      if (r_self_coll && !r_dead) begin
         if (w_len_mv == 4'd1) w_dead_nx = 1'b1;
         else                  w_len_nx  = w_len_mv - 4'd1;
      end
`endif
   end

   segment_match #(.N(MAX_SEGMENTS + 1)) u_player_match (
      .i_loc  (player_location),
      .i_locs ({r_seg_loc, r_head}),
      .i_mask ({w_valid, 1'b1}),
      .o_hit  (w_player_hit)
   );

   always_ff @(posedge frame_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head       <= START_LOC;
         r_head_dir   <= UP;
         r_seg_loc    <= {MAX_SEGMENTS{START_LOC}};
         r_seg_dir    <= '0;
         r_len        <= c_init_len;
         r_dead       <= 1'b0;
         r_player_hit <= 1'b0;
      end else begin
         r_player_hit <= w_player_hit;
         r_len        <= w_len_nx;
         r_dead       <= w_dead_nx;
         if (w_move) begin
            r_head     <= head_location;
            r_head_dir <= dir_t'(head_direction);
            r_seg_loc  <= w_shift_loc;
            r_seg_dir  <= w_shift_dir;
         end
      end
   end

   assign body_length        = r_len;
   assign segment_locations  = r_seg_loc;
   assign segment_directions = r_seg_dir;
   assign segment_valid      = w_valid;
   assign head_q             = r_head;
   assign player_hit         = r_player_hit;
   assign dragon_dead        = r_dead;

endmodule

`default_nettype wire

// File: tb/tb_dragon_body.sv
// +----------------------------------------------------------------------------+
// | tb_dragon_body                                                             |
// | Directed self-checking bench for dragon_body (default parameters).        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dragon_body;

   logic         frame_clk;
   logic         rst_n;
   logic         move_valid;
   logic [7:0]   head_location;
   logic [1:0]   head_direction;
   logic         grow;
   logic         shrink;
   logic [7:0]   player_location;
   logic [3:0]   body_length;
   logic [119:0] segment_locations;
   logic [29:0]  segment_directions;
   logic [14:0]  segment_valid;
   logic [7:0]   head_q;
   logic         player_hit;
   logic         self_collision;
   logic         dragon_dead;

   int n_total = 0;
   int n_bad   = 0;

   dragon_body dut (
      .frame_clk          (frame_clk),
      .rst_n              (rst_n),
      .move_valid         (move_valid),
      .head_location      (head_location),
      .head_direction     (head_direction),
      .grow               (grow),
      .shrink             (shrink),
      .player_location    (player_location),
      .body_length        (body_length),
      .segment_locations  (segment_locations),
      .segment_directions (segment_directions),
      .segment_valid      (segment_valid),
      .head_q             (head_q),
      .player_hit         (player_hit),
      .self_collision     (self_collision),
      .dragon_dead        (dragon_dead)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the capturing edge.
   task automatic do_move(input logic [7:0] loc, input logic [1:0] dir,
                          input logic g, input logic s);
      move_valid     = 1'b1;
      head_location  = loc;
      head_direction = dir;
      grow           = g;
      shrink         = s;
      @(negedge frame_clk);
      move_valid = 1'b0;
      grow       = 1'b0;
      shrink     = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_head"},  head_q, 8'h77);
      chk({tag, "_len"},   body_length, 4'd2);
      chk({tag, "_valid"}, segment_valid, 15'h0003);
      chk({tag, "_locs"},  segment_locations, {15{8'h77}});
      chk({tag, "_dirs"},  segment_directions, 30'h0);
      chk({tag, "_dead"},  dragon_dead, 1'b0);
      chk({tag, "_phit"},  player_hit, 1'b0);
      chk({tag, "_self"},  self_collision, 1'b0);
   endtask

   initial begin
      logic [7:0] h;
      rst_n           = 1'b0;
      move_valid      = 1'b0;
      head_location   = 8'h00;
      head_direction  = 2'd0;
      grow            = 1'b0;
      shrink          = 1'b0;
      player_location = 8'h00;
      repeat (2) @(negedge frame_clk);
      rst_n = 1'b1;
      @(negedge frame_clk);
      check_reset_state("rst");

      // Plain moves: body follows head
      do_move(8'h78, 2'd1, 1'b0, 1'b0);
      do_move(8'h79, 2'd2, 1'b0, 1'b0);
      do_move(8'h7A, 2'd3, 1'b0, 1'b0);
      chk("mv_head",  head_q, 8'h7A);
      chk("mv_slot0", segment_locations[7:0], 8'h79);
      chk("mv_slot1", segment_locations[15:8], 8'h78);
      chk("mv_dir0",  segment_directions[1:0], 2'd2);
      chk("mv_dir1",  segment_directions[3:2], 2'd1);
      chk("mv_valid", segment_valid, 15'h0003);
      chk("mv_len",   body_length, 4'd2);

      // Growth exposes the vacated tile 78
      do_move(8'h7B, 2'd2, 1'b1, 1'b0);
      chk("g1_len", body_length, 4'd3);
      chk("g1_new", segment_locations[23:16], 8'h78);
      do_move(8'h7C, 2'd2, 1'b1, 1'b0);
      chk("g2_len", body_length, 4'd4);
      chk("g2_new", segment_locations[31:24], 8'h78);
      do_move(8'h7D, 2'd2, 1'b1, 1'b0);
      chk("g3_len", body_length, 4'd5);
      chk("g3_new", segment_locations[39:32], 8'h78);
      do_move(8'h7E, 2'd2, 1'b1, 1'b0);
      chk("g4_len",   body_length, 4'd6);
      chk("g4_new",   segment_locations[47:40], 8'h78);
      chk("g4_valid", segment_valid, 15'h003F);

      // Player hit: slot1=7C, head=7E, slot6=77 is not valid
      player_location = 8'h7C;
      @(negedge frame_clk);
      chk("phit_slot1", player_hit, 1'b1);
      player_location = 8'h00;
      @(negedge frame_clk);
      chk("phit_clear", player_hit, 1'b0);
      player_location = 8'h7E;
      @(negedge frame_clk);
      chk("phit_head", player_hit, 1'b1);
      player_location = 8'h77;
      @(negedge frame_clk);
      chk("phit_invalid", player_hit, 1'b0);
      player_location = 8'h00;

      // Grow to saturation, then one extra grow and a grow+shrink
      h = 8'h80;
      for (int i = 0; i < 9; i++) begin
         do_move(h, 2'd1, 1'b1, 1'b0);
         h++;
      end
      chk("sat_len15", body_length, 4'd15);
      do_move(h, 2'd1, 1'b1, 1'b0);
      h++;
      chk("sat_hold", body_length, 4'd15);
      chk("sat_valid", segment_valid, 15'h7FFF);
      do_move(h, 2'd1, 1'b1, 1'b1);
      h++;
      chk("both_hold", body_length, 4'd15);

      // Shrink down to 1, then shrink once more to die
      for (int i = 0; i < 14; i++) begin
         do_move(h, 2'd1, 1'b0, 1'b1);
         h++;
      end
      chk("shr_len1", body_length, 4'd1);
      chk("shr_alive", dragon_dead, 1'b0);
      do_move(h, 2'd1, 1'b0, 1'b1);
      chk("die_dead", dragon_dead, 1'b1);
      chk("die_len",  body_length, 4'd1);
      chk("die_head", head_q, h);
      do_move(8'hEE, 2'd0, 1'b1, 1'b0);
      chk("dead_head", head_q, h);
      chk("dead_len",  body_length, 4'd1);
      chk("dead_stick", dragon_dead, 1'b1);

      // Asynchronous reset between edges
      #3 rst_n = 1'b0;
      #1 check_reset_state("arst");
      @(negedge frame_clk);
      rst_n = 1'b1;
      @(negedge frame_clk);

      // Loop back onto the tail: 77->78->88->87->77 at length 4
      do_move(8'h78, 2'd1, 1'b1, 1'b0);
      chk("sc_m1", self_collision, 1'b0);
      do_move(8'h88, 2'd1, 1'b1, 1'b0);
      chk("sc_m2", self_collision, 1'b0);
      do_move(8'h87, 2'd2, 1'b0, 1'b0);
      chk("sc_m3", self_collision, 1'b0);
      chk("sc_len4", body_length, 4'd4);
      do_move(8'h77, 2'd3, 1'b0, 1'b0);
`ifdef DRAGON_SELF_COLLIDE_EN
      chk("sc_pulse", self_collision, 1'b1);
      chk("sc_len_pre", body_length, 4'd4);
      @(negedge frame_clk);
      chk("sc_pulse_end", self_collision, 1'b0);
      chk("sc_len_post", body_length, 4'd3);
`else
      chk("sc_nopulse", self_collision, 1'b0);
      @(negedge frame_clk);
      chk("sc_nopulse2", self_collision, 1'b0);
      chk("sc_len_post", body_length, 4'd4);
`endif
      chk("sc_head", head_q, 8'h77);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dragon_body.md
DRAGON_BODY -- requirements
Module: dragon_body

Interface
REQ-001 SHALL have parameter MAX_SEGMENTS, default 15: body segment slots, max body length.
REQ-002 SHALL have parameter INIT_LEN, default 2: body length after reset, range 1..MAX_SEGMENTS.
REQ-003 SHALL have parameter START_LOC, default 8'h77: head and all segment locations after reset.
REQ-004 SHALL have one clock and an asynchronous active-low reset: frame_clk in 1, rising edge; rst_n in 1, asynchronous, active-low.
REQ-005 SHALL have the port move_valid, in, 1 bit: one-cycle strobe meaning head_location/head_direction hold the new head state.
REQ-006 SHALL have the port head_location, in, 8 bits: new head tile, {x[7:4], y[3:0]}.
REQ-007 SHALL have the port head_direction, in, 2 bits: new head direction, 0=UP, 1=RIGHT, 2=DOWN, 3=LEFT.
REQ-008 SHALL have the ports grow and shrink, in, 1 bit each: length change requests, sampled only with move_valid.
REQ-009 SHALL have the port player_location, in, 8 bits: player tile.
REQ-010 SHALL have the port body_length, out, 4 bits: current body length.
REQ-011 SHALL have the port segment_locations, out, 8*MAX_SEGMENTS bits: slot i at bits [8i+7:8i], slot 0 next to the head.
REQ-012 SHALL have the port segment_directions, out, 2*MAX_SEGMENTS bits: per-slot direction, same ordering as segment_locations.
REQ-013 SHALL have the port segment_valid, out, MAX_SEGMENTS bits: bit i=1 iff i < body_length.
REQ-014 SHALL have the port head_q, out, 8 bits: registered current head location.
REQ-015 SHALL have the ports player_hit, self_collision and dragon_dead, out, 1 bit each.

Function
REQ-016 On move_valid and !dragon_dead, all of the following SHALL happen in one edge:
  - slot 0 <= {head_q, current head direction};
  - slot i <= slot i-1, for i = 1..MAX_SEGMENTS-1;
  - head_q <= head_location, and the head direction register <= head_direction.
REQ-017 Slots at or beyond body_length SHALL still shift, so that growth exposes the previously vacated tail tile.
REQ-018 Length update on move_valid SHALL be:
  - grow & !shrink: +1, saturating at MAX_SEGMENTS;
  - shrink & !grow: -1;
  - both or neither: unchanged.
REQ-019 Shrink at body_length==1 SHALL leave the length at 1 and set dragon_dead.
REQ-020 dragon_dead SHALL be sticky until reset; while set, all state registers SHALL hold and move_valid SHALL be ignored.
REQ-021 player_hit SHALL be registered each cycle: 1 iff player_location equals head_q or any valid segment, using state before the edge.
REQ-022 self_collision SHALL be a one-cycle pulse, the cycle after a move_valid where head_location equals any valid segment after the shift.
REQ-023 Location and direction compares SHALL be exact 8-bit equality, and head_q SHALL be stored unmodified with no coordinate wrap-around.
REQ-024 Latency from move_valid to updated outputs SHALL be 1 cycle.

Reset
REQ-025 rst_n low SHALL asynchronously reset, all values holding until the first move_valid after rst_n deasserts:
  - head_q and all slot locations = START_LOC;
  - all directions = UP;
  - body_length = INIT_LEN;
  - player_hit, self_collision, dragon_dead = 0.
REQ-026 Reset asserted mid-frame SHALL discard any pending update.

Configuration
REQ-027 With DRAGON_SELF_COLLIDE_EN defined, self_collision SHALL follow REQ-022, and a self_collision pulse SHALL also decrement body_length on the next edge with REQ-019 rules.
REQ-028 Without DRAGON_SELF_COLLIDE_EN, self_collision SHALL be constant 0 and the compare logic SHALL be absent.

Structure
REQ-029 A shared package SHALL hold:
  - direction constants UP/RIGHT/DOWN/LEFT;
  - LOC_W=8;
  - the default MAX_SEGMENTS.
REQ-030 Sub-module segment_match SHALL provide a combinational compare of one 8-bit location against a masked location array, returning any-hit; it SHALL be instanced for player_hit and self_collision.

Verification
REQ-031 Reset, then 3 move_valid with head 78,79,7A: head_q=7A, slot0=79, slot1=78, segment_valid=..011.
REQ-032 grow on 4 consecutive moves from length 2: body_length 3,4,5,6, with the newly valid slot holding the earlier vacated tile.
REQ-033 Length 15 plus grow gives 15; length 1 plus shrink gives dragon_dead=1, after which further move_valid leaves head_q unchanged.
REQ-034 player_location=slot1 location: player_hit=1 next cycle; player_location moved to 00 gives 0 next cycle.
REQ-035 Path 77→78→88→87→77 with length 4, DRAGON_SELF_COLLIDE_EN defined: self_collision pulses one cycle and body_length drops to 3; macro undefined: no pulse, length 4.
REQ-036 rst_n asserted low between move_valid strobes: all outputs return to reset values immediately, without waiting for a clock edge.
